// File: rtl/a_rf_sequencer_pkg.sv
// Shared types and sizes for the A register-file sequencer.
// The CFG state exists only when A_RF_SEQ_CFG_EN is defined.
package a_rf_seq_pkg;
  localparam int RF_SIZE_DEF = 8;
  localparam int PASSES_W    = 4;

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    FLUSH,
    READ,
    DONE
`ifdef A_RF_SEQ_CFG_EN
    , CFG
`endif
  } state_t;
endpackage

// File: rtl/a_rf_sequencer_if.sv
// Operand handshake and register-file control bus between the sequencer and the A datapath.
interface a_rf_sequencer_if #(
  parameter int ADDR_W = 3
);
  logic              a_valid;
  logic              a_ready;
  logic              RF_load;
  logic              CEA1;
  logic              CEA2;
  logic [ADDR_W-1:0] A_addr;
  logic              MDR;
  logic              mult_valid;

  modport master (
    input  a_valid,
    output a_ready, RF_load, CEA1, CEA2, A_addr, MDR, mult_valid
  );

  modport slave (
    output a_valid,
    input  a_ready, RF_load, CEA1, CEA2, A_addr, MDR, mult_valid
  );
endinterface

// File: rtl/a_rf_sequencer_cfg_shifter.sv
// Two-bit serial configuration loader (used only when A_RF_SEQ_CFG_EN is defined):
// shifts cfg_bits out LSB first with an enable that lasts exactly two cycles.
module a_rf_cfg_shifter (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       load,
  input  logic [1:0] bits,
  output logic       cfg_in,
  output logic       cfg_en,
  output logic       last
);
  logic [1:0] sh;
  logic [1:0] en;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sh <= '0;
      en <= '0;
    end else if (load) begin
      sh <= bits;
      en <= 2'b11;
    end else begin
      sh <= {1'b0, sh[1]};
      en <= {1'b0, en[1]};
    end
  end

  assign cfg_en = en[0];
  assign cfg_in = en[0] & sh[0];
  assign last   = en[0] & ~en[1];
endmodule

// File: rtl/a_rf_sequencer.sv
// A register-file load/read sequencer: loads N words, then sweeps the read address P times.
// Optional serial configuration load is enabled by defining A_RF_SEQ_CFG_EN.
module a_rf_sequencer
  import a_rf_seq_pkg::*;
#(
  parameter int RF_SIZE     = RF_SIZE_DEF,
  parameter int RF_SIZE_LOG = $clog2(RF_SIZE)
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   start,
  input  logic [RF_SIZE_LOG-1:0] load_count,
  input  logic [PASSES_W-1:0]    passes,
  input  logic                   mdr_mode,
  a_rf_sequencer_if.master       dp,
  output logic                   busy,
  output logic                   done,
  output logic                   err,
  input  logic                   cfg_start,
  input  logic [1:0]             cfg_bits,
  output logic                   configuration_input,
  output logic                   configuration_enable
);
  localparam logic [RF_SIZE_LOG-1:0] ONE  = 1;
  localparam logic [RF_SIZE_LOG-1:0] TWO  = 2;
  localparam logic [PASSES_W-1:0]    ONEP = 1;

  state_t                 state;
  logic [RF_SIZE_LOG-1:0] n_r;
  logic [RF_SIZE_LOG-1:0] cnt;
  logic [PASSES_W-1:0]    pass_left;
  logic                   mdr_r;
  logic                   err_r;
  logic                   legal;
  logic                   cfg_go;
  logic                   cfg_last;
  logic [RF_SIZE_LOG-1:0] first_addr;
  logic [RF_SIZE_LOG-1:0] step;

  // Pair mode needs an even word count so every read covers two registers.
  assign legal = (load_count != '0) && (int'(load_count) <= RF_SIZE - 1) &&
                 !(mdr_mode && load_count[0]);
  assign first_addr = mdr_r ? (n_r - ONE) : n_r;
  assign step       = mdr_r ? TWO : ONE;

`ifdef A_RF_SEQ_CFG_EN
  logic cfg_load;
  assign cfg_go   = cfg_start;
  assign cfg_load = (state == IDLE) && cfg_start;

  a_rf_cfg_shifter u_cfg (
    .clk    (clk),
    .rst_n  (rst_n),
    .load   (cfg_load),
    .bits   (cfg_bits),
    .cfg_in (configuration_input),
    .cfg_en (configuration_enable),
    .last   (cfg_last)
  );
`else
  logic unused_cfg;
  assign unused_cfg           = ^{cfg_start, cfg_bits};
  assign cfg_go               = 1'b0;
  assign cfg_last             = 1'b0;
  assign configuration_input  = 1'b0;
  assign configuration_enable = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      n_r       <= '0;
      cnt       <= '0;
      pass_left <= '0;
      mdr_r     <= 1'b0;
      err_r     <= 1'b0;
    end else begin
      err_r <= 1'b0;
      unique case (state)
        IDLE: begin
          if (cfg_go) begin
`ifdef A_RF_SEQ_CFG_EN
            state <= CFG;
`endif
          end else if (start) begin
            if (legal) begin
              n_r       <= load_count;
              mdr_r     <= mdr_mode;
              pass_left <= (passes == '0) ? '0 : passes - ONEP;
              cnt       <= '0;
              state     <= LOAD;
            end else begin
              err_r <= 1'b1;
            end
          end
        end
        LOAD: begin
          if (dp.a_valid) begin
            if (cnt == n_r - ONE) begin
              cnt   <= first_addr;
              state <= FLUSH;
            end else begin
              cnt <= cnt + ONE;
            end
          end
        end
        FLUSH: state <= READ;
        READ: begin
          // Address 1 closes every sweep in both normal and pair mode.
          if (cnt == ONE) begin
            if (pass_left == '0) begin
              cnt   <= '0;
              state <= DONE;
            end else begin
              pass_left <= pass_left - ONEP;
              cnt       <= first_addr;
            end
          end else begin
            cnt <= cnt - step;
          end
        end
        DONE: state <= IDLE;
`ifdef A_RF_SEQ_CFG_EN
        CFG: if (cfg_last) state <= DONE;
`endif
        default: state <= IDLE;
      endcase
    end
  end

  assign dp.a_ready    = (state == LOAD);
  assign dp.RF_load    = ((state == LOAD) && dp.a_valid) || (state == FLUSH);
  assign dp.CEA1       = 1'b0;
  assign dp.CEA2       = 1'b0;
  assign dp.A_addr     = (state == READ) ? cnt : '0;
  assign dp.MDR        = (state == READ) && mdr_r;
  assign dp.mult_valid = (state == READ);
  assign busy          = (state != IDLE);
  assign done          = (state == DONE);
  assign err           = err_r;
endmodule
